p2_fill_merge_pe: RTL and testbench

Second-generation MatRaptor processing element.
- Fills NQ row-local queues: one sorted partial-product vector per queue.
- After the row ends, runs a k-way merge phase that emits one column-sorted output row.
- With MERGE_ADD=1, duplicate columns are summed into a single entry.
- Sits behind the column demux of matraptor_core; replaces the fill-only PE, which had no drain/merge path.

---
 rtl/matraptor_pkg.sv | 21 ++
 rtl/mq_min_select.sv | 47 ++++
 rtl/p2_fill_merge_pe.sv | 272 +++++++++++++++++++++++++++
 tb/tb_p2_fill_merge_pe.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matraptor_pkg.sv
// Shared definitions for the MatRaptor processing elements.
package matraptor_pkg;

  // Ceiling log2 for sizing pointers and indices; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Row processing phases of the fill/merge PE.
  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_MERGE = 2'd1,
    S_FLUSH = 2'd2
  } pe_state_t;

endpackage

// File: rtl/mq_min_select.sv
// Combinational k-way minimum finder over the queue heads.
// Heap-ordered binary compare tree: node n has children 2n+1 / 2n+2 and
// leaves sit at NQ-1+i, so the left child always covers lower queue indices
// and wins on equal columns.
module mq_min_select
  import matraptor_pkg::*;
#(
  parameter int NQ    = 8,
  parameter int IDX_W = 16
) (
  input  logic [NQ*IDX_W-1:0]   head_cols,
  input  logic [NQ-1:0]         valid_mask,
  output logic [clog2(NQ)-1:0]  sel_idx,
  output logic [IDX_W-1:0]      sel_col,
  output logic                  any_valid
);

  localparam int QW = clog2(NQ);
  localparam int NN = 2 * NQ - 1;

  logic [NN-1:0]    v_n;
  logic [IDX_W-1:0] c_n [NN];
  logic [QW-1:0]    i_n [NN];

  genvar gi;

  // Leaves carry one queue head each.
  for (gi = 0; gi < NQ; gi++) begin : g_leaf
    assign v_n[NQ-1+gi] = valid_mask[gi];
    assign c_n[NQ-1+gi] = head_cols[gi*IDX_W +: IDX_W];
    assign i_n[NQ-1+gi] = QW'(gi);
  end

  // Internal nodes: right child only wins with a strictly smaller column.
  for (gi = 0; gi < NQ - 1; gi++) begin : g_node
    logic take_r;
    assign take_r   = v_n[2*gi+2] && (!v_n[2*gi+1] || (c_n[2*gi+2] < c_n[2*gi+1]));
    assign v_n[gi]  = v_n[2*gi+1] | v_n[2*gi+2];
    assign c_n[gi]  = take_r ? c_n[2*gi+2] : c_n[2*gi+1];
    assign i_n[gi]  = take_r ? i_n[2*gi+2] : i_n[2*gi+1];
  end

  assign any_valid = v_n[0];
  assign sel_col   = c_n[0];
  assign sel_idx   = i_n[0];

endmodule

// File: rtl/p2_fill_merge_pe.sv
// Fill/merge processing element: buffers one row's sorted partial-product
// vectors in NQ queues, then k-way merges them into one column-sorted row.
module p2_fill_merge_pe
  import matraptor_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 16,
  parameter int NQ        = 8,
  parameter int Q_DEPTH   = 256,
  parameter int MERGE_ADD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_val,
  input  logic [IDX_W-1:0]  in_row,
  input  logic [IDX_W-1:0]  in_col,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_val,
  output logic [IDX_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col,
  output logic              out_last,
  output logic              row_done,
  output logic              busy,
  output logic              err_overflow
);

  localparam int QW = clog2(NQ);
  localparam int CW = QW + 1;        // extra bit flags "ran past the last queue"
  localparam int AW = clog2(Q_DEPTH);
  localparam int PW = AW + 1;        // extra MSB separates full from empty

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [IDX_W-1:0]  col;
  } entry_t;

  pe_state_t         state_q, state_d;
  logic [CW-1:0]     cur_q_q, cur_q_d;
  logic              first_q, first_d;
  logic [IDX_W-1:0]  prev_col_q, prev_col_d;
  logic [IDX_W-1:0]  cur_row_q, cur_row_d;
  logic [PW-1:0]     wr_ptr_q [NQ];
  logic [PW-1:0]     wr_ptr_d [NQ];
  logic [PW-1:0]     rd_ptr_q [NQ];
  logic [PW-1:0]     rd_ptr_d [NQ];
  logic              acc_valid_q, acc_valid_d;
  logic [DATA_W-1:0] acc_val_q, acc_val_d;
  logic [IDX_W-1:0]  acc_col_q, acc_col_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_val_q, out_val_d;
  logic [IDX_W-1:0]  out_row_q, out_row_d;
  logic [IDX_W-1:0]  out_col_q, out_col_d;
  logic              err_q, err_d;

  entry_t            head [NQ];
  entry_t            wr_data;
  logic [NQ-1:0]     q_empty;
  logic [NQ-1:0]     q_full;
  logic [NQ-1:0]     wr_en;
  logic [NQ*IDX_W-1:0] head_cols;
  logic [QW-1:0]     sel_idx;
  logic [IDX_W-1:0]  sel_col;
  logic [DATA_W-1:0] sel_val;
  logic              any_valid;
  logic              out_free;
  logic              pop;
  logic              clear;
  logic [CW-1:0]     tgt;

  assign wr_data = '{val: in_val, col: in_col};

  genvar gi;

  // Per-queue storage and status; heads are read combinationally for the merge.
  for (gi = 0; gi < NQ; gi++) begin : g_q
    entry_t mem [Q_DEPTH];

    // Queue write port, used only while filling.
    always_ff @(posedge clk) begin
      if (wr_en[gi]) begin
        mem[wr_ptr_q[gi][AW-1:0]] <= wr_data;
      end
    end

    assign head[gi]    = mem[rd_ptr_q[gi][AW-1:0]];
    assign q_empty[gi] = (wr_ptr_q[gi] == rd_ptr_q[gi]);
    assign q_full[gi]  = (wr_ptr_q[gi][PW-1] != rd_ptr_q[gi][PW-1]) &&
                         (wr_ptr_q[gi][AW-1:0] == rd_ptr_q[gi][AW-1:0]);
    assign head_cols[gi*IDX_W +: IDX_W] = head[gi].col;
  end

  mq_min_select #(
    .NQ    (NQ),
    .IDX_W (IDX_W)
  ) u_min_select (
    .head_cols  (head_cols),
    .valid_mask (~q_empty),
    .sel_idx    (sel_idx),
    .sel_col    (sel_col),
    .any_valid  (any_valid)
  );

  assign sel_val  = head[sel_idx].val;
  assign out_free = !out_valid_q || out_ready;

  // Next-state logic for fill, merge and flush phases.
  always_comb begin
    state_d     = state_q;
    cur_q_d     = cur_q_q;
    first_d     = first_q;
    prev_col_d  = prev_col_q;
    cur_row_d   = cur_row_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    acc_valid_d = acc_valid_q;
    acc_val_d   = acc_val_q;
    acc_col_d   = acc_col_q;
    out_valid_d = out_valid_q && !out_ready;
    out_last_d  = out_last_q;
    out_val_d   = out_val_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    err_d       = err_q;
    wr_en       = '0;
    pop         = 1'b0;
    clear       = 1'b0;
    tgt         = cur_q_q;

    unique case (state_q)
      S_FILL: begin
        if (in_valid) begin
          // A non-increasing column starts the next vector; saturate once past NQ-1.
          if (!first_q && (in_col <= prev_col_q) && !cur_q_q[QW]) begin
            tgt = cur_q_q + CW'(1);
          end
          cur_q_d    = tgt;
          prev_col_d = in_col;
          first_d    = 1'b0;
          if (first_q) begin
            cur_row_d = in_row;
          end
          if (tgt[QW] || q_full[tgt[QW-1:0]]) begin
            err_d = 1'b1;
          end else begin
            wr_en[tgt[QW-1:0]]    = 1'b1;
            wr_ptr_d[tgt[QW-1:0]] = wr_ptr_q[tgt[QW-1:0]] + PW'(1);
          end
          if (in_last) begin
            state_d = S_MERGE;
          end
        end
      end

      S_MERGE: begin
        if (!any_valid) begin
          // A fully dropped row never loaded the accumulator and emits nothing.
          if (acc_valid_q) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_FILL;
            clear   = 1'b1;
          end
        end else if (!acc_valid_q) begin
          pop         = 1'b1;
          acc_valid_d = 1'b1;
          acc_val_d   = sel_val;
          acc_col_d   = sel_col;
        end else if ((MERGE_ADD != 0) && (sel_col == acc_col_q)) begin
          pop       = 1'b1;
          acc_val_d = acc_val_q + sel_val;
        end else if (out_free) begin
          pop         = 1'b1;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          out_val_d   = acc_val_q;
          out_col_d   = acc_col_q;
          out_row_d   = cur_row_q;
          acc_val_d   = sel_val;
          acc_col_d   = sel_col;
        end
      end

      S_FLUSH: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          out_val_d   = acc_val_q;
          out_col_d   = acc_col_q;
          out_row_d   = cur_row_q;
          state_d     = S_FILL;
          clear       = 1'b1;
        end
      end

      default: begin
        state_d = S_FILL;
        clear   = 1'b1;
      end
    endcase

    if (pop) begin
      rd_ptr_d[sel_idx] = rd_ptr_q[sel_idx] + PW'(1);
    end

    if (clear) begin
      for (int i = 0; i < NQ; i++) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
      end
      cur_q_d     = '0;
      first_d     = 1'b1;
      acc_valid_d = 1'b0;
    end
  end

  // State, pointer, accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      cur_q_q     <= '0;
      first_q     <= 1'b1;
      prev_col_q  <= '0;
      cur_row_q   <= '0;
      for (int i = 0; i < NQ; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      acc_valid_q <= 1'b0;
      acc_val_q   <= '0;
      acc_col_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_val_q   <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q_q     <= cur_q_d;
      first_q     <= first_d;
      prev_col_q  <= prev_col_d;
      cur_row_q   <= cur_row_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      acc_valid_q <= acc_valid_d;
      acc_val_q   <= acc_val_d;
      acc_col_q   <= acc_col_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_val_q   <= out_val_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      err_q       <= err_d;
    end
  end

  assign in_ready     = (state_q == S_FILL);
  assign busy         = (state_q == S_MERGE) || (state_q == S_FLUSH);
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign out_val      = out_val_q;
  assign out_row      = out_row_q;
  assign out_col      = out_col_q;
  assign row_done     = out_valid_q && out_last_q && out_ready;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_p2_fill_merge_pe.sv
// Bench: three PE configurations driven with identical rows, each checked
// against a sort-and-combine reference model of the row semantics.
module tb_p2_fill_merge_pe;

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
    logic [31:0] val;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_val;
  logic [15:0] in_row;
  logic [15:0] in_col;
  logic        in_last;
  logic        out_ready;
  logic [2:0]  in_ready_v, ov, olast, rdone, busy_v, err_v;
  logic [31:0] oval [3];
  logic [15:0] orow [3];
  logic [15:0] ocol [3];

  int          checks;
  int          failures;
  int          stab_err;
  int          ir_err;
  int          rd_cnt [3];
  int          exp_rd [3];
  bit          err_exp [3];
  bit          rnd_ready;
  bit          held [3];
  beat_t       held_b [3];
  beat_t       obs_q [3][$];
  beat_t       exp_q [3][$];
  logic [15:0] stim_col [$];
  logic [31:0] stim_val [$];

  // A: default-style merge; B: duplicates kept; C: tiny queues to force drops.
  p2_fill_merge_pe #(.NQ(4), .Q_DEPTH(8), .MERGE_ADD(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .in_val(in_val), .in_row(in_row), .in_col(in_col), .in_last(in_last),
    .out_valid(ov[0]), .out_ready(out_ready), .out_val(oval[0]), .out_row(orow[0]),
    .out_col(ocol[0]), .out_last(olast[0]), .row_done(rdone[0]), .busy(busy_v[0]),
    .err_overflow(err_v[0]));

  p2_fill_merge_pe #(.NQ(4), .Q_DEPTH(8), .MERGE_ADD(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .in_val(in_val), .in_row(in_row), .in_col(in_col), .in_last(in_last),
    .out_valid(ov[1]), .out_ready(out_ready), .out_val(oval[1]), .out_row(orow[1]),
    .out_col(ocol[1]), .out_last(olast[1]), .row_done(rdone[1]), .busy(busy_v[1]),
    .err_overflow(err_v[1]));

  p2_fill_merge_pe #(.NQ(2), .Q_DEPTH(4), .MERGE_ADD(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .in_val(in_val), .in_row(in_row), .in_col(in_col), .in_last(in_last),
    .out_valid(ov[2]), .out_ready(out_ready), .out_val(oval[2]), .out_row(orow[2]),
    .out_col(ocol[2]), .out_last(olast[2]), .row_done(rdone[2]), .busy(busy_v[2]),
    .err_overflow(err_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream: always ready, or a random 50% ready pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: collect beats, count row_done, check hold-while-stalled.
  always @(negedge clk) begin
    beat_t b;
    for (int d = 0; d < 3; d++) begin
      if (rst_n) begin
        b = '{row: orow[d], col: ocol[d], val: oval[d], last: olast[d]};
        if (held[d] && (!ov[d] || (b !== held_b[d]))) stab_err++;
        held[d]   = ov[d] && !out_ready;
        held_b[d] = b;
        if (ov[d] && out_ready) obs_q[d].push_back(b);
        if (rdone[d]) rd_cnt[d]++;
        if (busy_v[d] && in_ready_v[d]) ir_err++;
      end else begin
        held[d] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: split the stream into vectors, drop what does not fit,
  // stable-sort by column (lower queue first), then combine equal columns.
  task automatic model_row(input int d, input int nq, input int qd, input bit ma,
                           input logic [15:0] row);
    int          vec;
    int          cnt [8];
    int          kq [$];
    logic [15:0] kc [$];
    logic [31:0] kv [$];
    beat_t       srt [$];
    beat_t       mrg [$];
    beat_t       b;
    vec = 0;
    foreach (cnt[i]) cnt[i] = 0;
    for (int i = 0; i < stim_col.size(); i++) begin
      if (i > 0 && stim_col[i] <= stim_col[i-1]) vec++;
      if (vec >= nq || cnt[vec] >= qd) begin
        err_exp[d] = 1'b1;
      end else begin
        cnt[vec]++;
        kq.push_back(vec);
        kc.push_back(stim_col[i]);
        kv.push_back(stim_val[i]);
      end
    end
    for (int q = 0; q < nq; q++) begin
      for (int k = 0; k < kq.size(); k++) begin
        if (kq[k] == q) begin
          int pos;
          pos = srt.size();
          while (pos > 0 && srt[pos-1].col > kc[k]) pos--;
          b = '{row: row, col: kc[k], val: kv[k], last: 1'b0};
          srt.insert(pos, b);
        end
      end
    end
    foreach (srt[i]) begin
      if (ma && mrg.size() > 0 && mrg[mrg.size()-1].col == srt[i].col) begin
        b = mrg[mrg.size()-1];
        b.val = b.val + srt[i].val;
        mrg[mrg.size()-1] = b;
      end else begin
        mrg.push_back(srt[i]);
      end
    end
    if (mrg.size() > 0) begin
      b = mrg[mrg.size()-1];
      b.last = 1'b1;
      mrg[mrg.size()-1] = b;
      exp_rd[d]++;
    end
    foreach (mrg[i]) exp_q[d].push_back(mrg[i]);
  endtask

  task automatic model_all(input logic [15:0] row);
    model_row(0, 4, 8, 1'b1, row);
    model_row(1, 4, 8, 1'b0, row);
    model_row(2, 2, 4, 1'b1, row);
  endtask

  task automatic send_row(input logic [15:0] row);
    for (int i = 0; i < stim_col.size(); i++) begin
      in_valid = 1'b1;
      in_row   = row;
      in_col   = stim_col[i];
      in_val   = stim_val[i];
      in_last  = (i == stim_col.size() - 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (((busy_v != 3'b000) || (ov != 3'b000)) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".idle_timeout"}, 128'(n < 3000), 128'(1));
  endtask

  task automatic compare_row(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s.dut%0d.beats", tag, d), 128'(obs_q[d].size()), 128'(exp_q[d].size()));
      for (int i = 0; i < exp_q[d].size() && i < obs_q[d].size(); i++) begin
        chk($sformatf("%s.dut%0d.beat%0d", tag, d, i), 128'(obs_q[d][i]), 128'(exp_q[d][i]));
      end
      $display("row %s dut%0d: %0d beats observed, %0d expected", tag, d,
               obs_q[d].size(), exp_q[d].size());
      obs_q[d].delete();
      exp_q[d].delete();
    end
  endtask

  task automatic set_case1();
    stim_col.delete();
    stim_val.delete();
    stim_col = '{16'd1, 16'd4, 16'd1, 16'd6};
    stim_val = '{32'd5, 32'd2, 32'd7, 32'd1};
  endtask

  initial begin
    int nv, len, c;
    checks = 0; failures = 0; stab_err = 0; ir_err = 0; rnd_ready = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rd_cnt[d] = 0; exp_rd[d] = 0; err_exp[d] = 1'b0; held[d] = 1'b0;
    end
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_val = '0; in_row = '0; in_col = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state of every instance.
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset.dut%0d.out_valid", d), 128'(ov[d]), 128'(0));
      chk($sformatf("reset.dut%0d.in_ready", d), 128'(in_ready_v[d]), 128'(1));
      chk($sformatf("reset.dut%0d.busy", d), 128'(busy_v[d]), 128'(0));
      chk($sformatf("reset.dut%0d.err", d), 128'(err_v[d]), 128'(0));
      chk($sformatf("reset.dut%0d.data", d), {orow[d], ocol[d], oval[d], olast[d], rdone[d]}, 128'(0));
    end

    // Two-vector row, always-ready sink.
    set_case1();
    model_all(16'd3);
    send_row(16'd3);
    wait_idle("case1");
    compare_row("case1");

    // Same row with a stalling sink.
    rnd_ready = 1'b1;
    set_case1();
    model_all(16'd3);
    send_row(16'd3);
    wait_idle("case1_stall");
    compare_row("case1_stall");
    rnd_ready = 1'b0;

    // Three single-entry vectors on column 0: exceeds NQ=2 in instance C.
    stim_col.delete(); stim_val.delete();
    stim_col = '{16'd0, 16'd0, 16'd0};
    stim_val = '{32'd1, 32'd1, 32'd1};
    model_all(16'd0);
    send_row(16'd0);
    wait_idle("too_many_vectors");
    compare_row("too_many_vectors");

    // Five ascending columns: exceeds Q_DEPTH=4 in instance C.
    stim_col.delete(); stim_val.delete();
    for (int i = 0; i < 5; i++) begin
      stim_col.push_back(16'(i));
      stim_val.push_back($urandom());
    end
    model_all(16'd1);
    send_row(16'd1);
    wait_idle("queue_full");
    compare_row("queue_full");
    for (int d = 0; d < 3; d++)
      chk($sformatf("sticky.dut%0d.err", d), 128'(err_v[d]), 128'(err_exp[d]));

    // Random rows with a random sink.
    rnd_ready = 1'b1;
    for (int r = 0; r < 10; r++) begin
      stim_col.delete(); stim_val.delete();
      nv = $urandom_range(1, 4);
      for (int v = 0; v < nv; v++) begin
        c = $urandom_range(0, 3);
        len = $urandom_range(1, 5);
        for (int k = 0; k < len; k++) begin
          stim_col.push_back(16'(c));
          stim_val.push_back(($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 15)));
          c = c + $urandom_range(1, 3);
        end
      end
      model_all(16'(20 + r));
      send_row(16'(20 + r));
      wait_idle($sformatf("rand%0d", r));
      compare_row($sformatf("rand%0d", r));
    end
    rnd_ready = 1'b0;

    for (int d = 0; d < 3; d++) begin
      chk($sformatf("final.dut%0d.err", d), 128'(err_v[d]), 128'(err_exp[d]));
      chk($sformatf("final.dut%0d.row_done_count", d), 128'(rd_cnt[d]), 128'(exp_rd[d]));
    end
    chk("stall_hold_violations", 128'(stab_err), 128'(0));
    chk("in_ready_while_busy", 128'(ir_err), 128'(0));

    // Reset while merging: in-flight row is lost, next row is clean.
    stim_col.delete(); stim_val.delete();
    for (int v = 0; v < 3; v++)
      for (int k = 0; k < 4; k++) begin
        stim_col.push_back(16'(k));
        stim_val.push_back($urandom());
      end
    send_row(16'd5);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midreset.dut%0d.out_valid", d), 128'(ov[d]), 128'(0));
      chk($sformatf("midreset.dut%0d.busy", d), 128'(busy_v[d]), 128'(0));
      chk($sformatf("midreset.dut%0d.err", d), 128'(err_v[d]), 128'(0));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      obs_q[d].delete(); exp_q[d].delete();
      rd_cnt[d] = 0; exp_rd[d] = 0; err_exp[d] = 1'b0;
    end
    @(posedge clk);
    #1;
    stim_col.delete(); stim_val.delete();
    stim_col.push_back(16'd2);
    stim_val.push_back(32'd9);
    model_all(16'd7);
    send_row(16'd7);
    wait_idle("after_reset");
    compare_row("after_reset");
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("after_reset.dut%0d.err", d), 128'(err_v[d]), 128'(0));
      chk($sformatf("after_reset.dut%0d.row_done_count", d), 128'(rd_cnt[d]), 128'(exp_rd[d]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
